// File: rtl/controller_pkg.sv
// Shared types for the multi-cycle controller: FSM states, the legal 3-bit
// opcode encodings and the coarse instruction classes the FSM branches on.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        TRAP
    } state_t;

    localparam logic [2:0] OP_STORE = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        MEMST,
        MEMLD,
        ALU,
        BR,
        STOP,
        BAD
    } op_class_t;

endpackage

// File: rtl/multicycle_controller_op_classifier.sv
// Combinational opcode classifier. Any set bit above the low three bits
// makes the opcode illegal regardless of the low encoding.
module op_classifier
    import controller_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [OP_W-1:0] op,
    output op_class_t       op_class
);

    logic upper_nz;

    generate
        if (OP_W > 3) begin : g_upper
            assign upper_nz = |op[OP_W-1:3];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        op_class = BAD;
        if (!upper_nz) begin
            case (op[2:0])
                OP_STORE: op_class = MEMST;
                OP_LOAD:  op_class = MEMLD;
                OP_ADD:   op_class = ALU;
                OP_BEQ:   op_class = BR;
                OP_HALT:  op_class = STOP;
                default:  op_class = BAD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing with a
// memory-wait timeout trap and a retired-instruction counter.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int OP_W        = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             regWrite,
    output logic             memToReg,
    output logic             addition,
    output logic             aluF,
    output logic             branch,
    output logic             halt,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int                 WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [OP_W-1:0]   op_q;
    logic [WAIT_W-1:0] wait_reg;
    logic [CNT_W-1:0]  retired_reg;
    op_class_t         live_class, held_class;
    logic              retire;
    logic              timed_out;

    // Live op only steers the DECODE transition; everything later uses op_q.
    op_classifier #(.OP_W(OP_W)) u_live_class (
        .op       (op),
        .op_class (live_class)
    );

    op_classifier #(.OP_W(OP_W)) u_held_class (
        .op       (op_q),
        .op_class (held_class)
    );

    // This cycle would be the MEM_TIMEOUT-th consecutive wait; a ready in the
    // same cycle is not a wait, so it completes normally.
    assign timed_out = !mem_ready && (wait_reg == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            op_q        <= '0;
            wait_reg    <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                op_q <= op;
            end
            if (state_next != state_reg) begin
                wait_reg <= '0;
            end else if ((state_reg == FETCH || state_reg == MEM) && !mem_ready) begin
                wait_reg <= wait_reg + 1'b1;
            end
            if (retire) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        regWrite   = 1'b0;
        memToReg   = 1'b0;
        addition   = 1'b0;
        aluF       = 1'b0;
        branch     = 1'b0;
        halt       = 1'b0;
        illegal    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                memRead = 1'b1;
                if (mem_ready) begin
                    irWrite    = 1'b1;
                    pcWrite    = 1'b1;
                    state_next = DECODE;
                end else if (timed_out) begin
                    state_next = TRAP;
                end
            end
            DECODE: begin
                case (live_class)
                    MEMST, MEMLD: state_next = MEM;
                    ALU, BR:      state_next = EXEC;
                    STOP: begin
                        state_next = HALT;
                        retire     = 1'b1;
                    end
                    default:      state_next = TRAP;
                endcase
            end
            EXEC: begin
                case (held_class)
                    ALU: begin
                        addition   = 1'b1;
                        state_next = WB;
                    end
                    BR: begin
                        aluF       = 1'b1;
                        branch     = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    default: state_next = TRAP;
                endcase
            end
            MEM: begin
                case (held_class)
                    MEMST: begin
                        memWrite = 1'b1;
                        if (mem_ready) begin
                            retire     = 1'b1;
                            state_next = FETCH;
                        end else if (timed_out) begin
                            state_next = TRAP;
                        end
                    end
                    MEMLD: begin
                        memRead = 1'b1;
                        if (mem_ready) begin
                            state_next = WB;
                        end else if (timed_out) begin
                            state_next = TRAP;
                        end
                    end
                    default: state_next = TRAP;
                endcase
            end
            WB: begin
                regWrite   = 1'b1;
                memToReg   = (held_class == MEMLD);
                retire     = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
                halt = 1'b1;
            end
            TRAP: begin
                halt    = 1'b1;
                illegal = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench: each instruction is expanded into the
// expected per-cycle control pattern and compared against the controller.
module tb_multicycle_controller;

    localparam int OP_W        = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 2;

    localparam logic [10:0] IRW = 11'h400;
    localparam logic [10:0] PCW = 11'h200;
    localparam logic [10:0] MRD = 11'h100;
    localparam logic [10:0] MWR = 11'h080;
    localparam logic [10:0] RGW = 11'h040;
    localparam logic [10:0] M2R = 11'h020;
    localparam logic [10:0] ADD = 11'h010;
    localparam logic [10:0] ALF = 11'h008;
    localparam logic [10:0] BRN = 11'h004;
    localparam logic [10:0] HLT = 11'h002;
    localparam logic [10:0] ILL = 11'h001;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [OP_W-1:0]  op;
    logic             mem_ready;
    logic             irWrite, pcWrite, memRead, memWrite, regWrite, memToReg;
    logic             addition, aluF, branch, halt, illegal;
    logic [CNT_W-1:0] retired;
    logic [10:0]      ctl;

    int n_tests = 0;
    int n_fail  = 0;
    int model_retired = 0;

    always #5 clk = ~clk;

    assign ctl = {irWrite, pcWrite, memRead, memWrite, regWrite, memToReg,
                  addition, aluF, branch, halt, illegal};

    multicycle_controller #(
        .OP_W        (OP_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .mem_ready (mem_ready),
        .irWrite   (irWrite),
        .pcWrite   (pcWrite),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .regWrite  (regWrite),
        .memToReg  (memToReg),
        .addition  (addition),
        .aluF      (aluF),
        .branch    (branch),
        .halt      (halt),
        .illegal   (illegal),
        .retired   (retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_ret();
        return 32'(model_retired % (1 << CNT_W));
    endfunction

    // One clock cycle: drive, check combinational outputs, advance to next negedge.
    task automatic step(input logic rdy, input logic [10:0] exp, input string tag);
        mem_ready = rdy;
        start     = 1'($urandom);
        #1;
        check({tag, "_ctl"}, 32'(ctl), 32'(exp));
        check({tag, "_ret"}, 32'(retired), model_ret());
        @(posedge clk);
        @(negedge clk);
    endtask

    // A memory access that needs w wait cycles; gives up after MEM_TIMEOUT waits.
    task automatic access(input int w, input logic [10:0] v, input bit is_fetch,
                          input string tag, output bit trapped);
        trapped = 1'b0;
        for (int k = 0; k <= w; k++) begin
            if (k == MEM_TIMEOUT) begin
                trapped = 1'b1;
                return;
            end
            step(k == w, (k == w && is_fetch) ? (v | IRW | PCW) : v, tag);
        end
    endtask

    task automatic hold_stopped(input logic [10:0] v, input int n, input string tag);
        for (int k = 0; k < n; k++) step(1'($urandom), v, tag);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        op        = '0;
        #1;
        check("reset_ctl", 32'(ctl), 32'h0);
        check("reset_ret", 32'(retired), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_retired = 0;
    endtask

    task automatic begin_run();
        start     = 1'b0;
        mem_ready = 1'($urandom);
        #1;
        check("idle_ctl", 32'(ctl), 32'h0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        #1;
        check("idle_start_ctl", 32'(ctl), 32'h0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Executes one instruction; done=1 when the machine has stopped.
    task automatic run_instr(input logic [OP_W-1:0] opv, input int fw, input int mw,
                             output bit done);
        bit t;
        done = 1'b0;
        access(fw, MRD, 1'b1, "fetch", t);
        if (t) begin
            hold_stopped(HLT | ILL, 3, "fetch_trap");
            done = 1'b1;
            return;
        end
        op = opv;
        step(1'($urandom), 11'h0, "decode");
        op = OP_W'($urandom);
        if (opv > OP_W'(7)) begin
            hold_stopped(HLT | ILL, 3, "op_trap");
            done = 1'b1;
            return;
        end
        case (opv[2:0])
            3'b000: begin
                access(mw, MWR, 1'b0, "mem_st", t);
                if (t) begin
                    hold_stopped(HLT | ILL, 3, "st_trap");
                    done = 1'b1;
                end else begin
                    model_retired++;
                end
            end
            3'b001: begin
                access(mw, MRD, 1'b0, "mem_ld", t);
                if (t) begin
                    hold_stopped(HLT | ILL, 3, "ld_trap");
                    done = 1'b1;
                end else begin
                    step(1'($urandom), RGW | M2R, "wb_ld");
                    model_retired++;
                end
            end
            3'b010: begin
                step(1'($urandom), ADD, "exec_add");
                step(1'($urandom), RGW, "wb_add");
                model_retired++;
            end
            3'b101: begin
                step(1'($urandom), ALF | BRN, "exec_beq");
                model_retired++;
            end
            3'b111: begin
                model_retired++;
                hold_stopped(HLT, 10, "halt");
                done = 1'b1;
            end
            default: begin
                hold_stopped(HLT | ILL, 3, "op_trap");
                done = 1'b1;
            end
        endcase
    endtask

    function automatic logic [OP_W-1:0] pick_op();
        int r;
        logic [2:0] bad3 [3];
        bad3[0] = 3'b011;
        bad3[1] = 3'b100;
        bad3[2] = 3'b110;
        r = $urandom_range(0, 99);
        if (r < 22) return OP_W'(0);
        if (r < 44) return OP_W'(1);
        if (r < 66) return OP_W'(2);
        if (r < 90) return OP_W'(5);
        if (r < 94) return OP_W'(7);
        if (r < 97) return OP_W'(bad3[$urandom_range(0, 2)]);
        return OP_W'($urandom_range(8, (1 << OP_W) - 1));
    endfunction

    function automatic int pick_wait();
        if ($urandom_range(0, 9) == 0) return $urandom_range(MEM_TIMEOUT - 1, MEM_TIMEOUT + 1);
        return $urandom_range(0, 2);
    endfunction

    initial begin
        bit done;
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        op        = '0;
        @(negedge clk);

        // Zero-wait load.
        do_reset(); begin_run();
        run_instr(OP_W'(1), 0, 0, done);
        check("load_retired", 32'(retired), 32'h1);

        // Store with three wait cycles in MEM, then fetch timeout.
        do_reset(); begin_run();
        run_instr(OP_W'(0), 0, 3, done);
        run_instr(OP_W'(2), MEM_TIMEOUT, 0, done);

        // Ready on the last allowed cycle completes the fetch.
        do_reset(); begin_run();
        run_instr(OP_W'(5), MEM_TIMEOUT - 1, 0, done);
        check("edge_wait_no_trap", 32'(illegal), 32'h0);

        do_reset(); begin_run(); run_instr(OP_W'(4'b1010), 0, 0, done);
        do_reset(); begin_run(); run_instr(OP_W'(3'b011), 0, 0, done);
        do_reset(); begin_run(); run_instr(OP_W'(7), 0, 0, done);

        // Five adds exercise counter wrap, then a halt.
        do_reset(); begin_run();
        for (int i = 0; i < 5; i++) run_instr(OP_W'(2), 0, 0, done);
        run_instr(OP_W'(7), 0, 0, done);

        // Asynchronous reset in the middle of a load's MEM state.
        do_reset(); begin_run();
        run_instr(OP_W'(2), 0, 0, done);
        access(0, MRD, 1'b1, "fetch", done);
        op = OP_W'(1);
        step(1'b0, 11'h0, "decode");
        op = OP_W'($urandom);
        mem_ready = 1'b0;
        #1;
        check("mid_mem_ctl", 32'(ctl), 32'(MRD));
        #1 reset = 1'b1;
        #1;
        check("async_rst_ctl", 32'(ctl), 32'h0);
        check("async_rst_ret", 32'(retired), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_retired = 0;
        begin_run();
        run_instr(OP_W'(1), 0, 0, done);
        run_instr(OP_W'(5), 1, 0, done);

        for (int s = 0; s < 40; s++) begin
            do_reset(); begin_run();
            done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                run_instr(pick_op(), pick_wait(), pick_wait(), done);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states instead of asserting all controls in one cycle. It waits on a variable-latency memory handshake and traps illegal opcodes or memory timeouts. It also keeps a retired-instruction counter. It sits between the instruction register / memory interface and the datapath.

## Interface
- OP_W, 3: opcode width, must be ≥ 3. Only the low 3-bit encodings listed below are legal; any nonzero upper bit is illegal.
- MEM_TIMEOUT, 16: maximum cycles a memory access may wait for mem_ready before trapping; must be ≥ 1.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE.
- op  in  OP_W  opcode from the instruction register; valid from the DECODE cycle onward.
- mem_ready  in  1  memory completes the current read or write this cycle.
- irWrite  out  1  load the instruction register.
- pcWrite  out  1  PC ← PC+1.
- memRead  out  1  memory read request (instruction or data).
- memWrite  out  1  memory write request.
- regWrite  out  1  register file write.
- memToReg  out  1  writeback source is memory data.
- addition  out  1  ALU performs add.
- aluF  out  1  ALU performs compare.
- branch  out  1  datapath takes the branch if compare is equal.
- halt  out  1  execution stopped.
- illegal  out  1  stopped due to a trap.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Legal opcodes: 000 store, 001 load, 010 add, 101 branch-if-equal, 111 halt. All others trap.
- The opcode is latched into op_q on the DECODE edge. Later states use op_q, never live op.
- IDLE: all controls 0. Go to FETCH when start=1.
- FETCH: memRead=1.
  - If mem_ready=1: irWrite=1 and pcWrite=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no controls asserted. Next state by op:
  - store or load → MEM
  - add or beq → EXEC
  - halt → HALT
  - anything else → TRAP
- EXEC:
  - add: addition=1, then WB.
  - beq: aluF=1 and branch=1, retire, then FETCH.
- MEM:
  - store: memWrite=1 until mem_ready, then retire and go to FETCH.
  - load: memRead=1 until mem_ready, then WB.
- WB: regWrite=1. memToReg=1 for load, 0 for add. Retire, then FETCH.
- HALT: halt=1, held until reset. The halt instruction itself is counted as retired on entry.
- TRAP: halt=1 and illegal=1, held until reset. Not counted as retired.
- Memory timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0.
  - Reaching MEM_TIMEOUT waiting cycles without mem_ready → TRAP.
  - mem_ready in the same cycle the limit is reached wins: the access completes normally.
- retired increments by exactly 1 per retire event and wraps modulo 2^CNT_W.
- start outside IDLE is ignored.
- mem_ready outside FETCH/MEM is ignored.

## Timing
- Reset (asynchronous, any state): state=IDLE, op_q=0, wait counter=0, retired=0, all control outputs 0.
- Control outputs are combinational from state, op_q and mem_ready only (Moore plus the mem_ready qualifier on irWrite/pcWrite). There is no path from op.
- Zero-wait latency, counted from the first FETCH cycle to the next FETCH cycle:
  - load: 4 cycles
  - add: 4 cycles
  - store: 3 cycles
  - beq: 3 cycles
- Each wait cycle adds 1 cycle to the instruction.
- halt is asserted 2 cycles after the first FETCH cycle of the halt instruction (zero wait).
- retired updates on the clock edge that leaves the retiring state, so it is visible in the next FETCH cycle.

## Structure
- Package controller_pkg holds:
  - state_t enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP
  - opcode localparams: OP_STORE, OP_LOAD, OP_ADD, OP_BEQ, OP_HALT
  - op_class_t enum: MEMST, MEMLD, ALU, BR, STOP, BAD
- Sub-module op_classifier (combinational, parameter OP_W): maps op to op_class_t, returning BAD for any nonzero upper bits. Used both in DECODE and on op_q.
- Top contains the state register, op_q, the wait counter ($clog2(MEM_TIMEOUT+1) bits), the retired counter, and the output decode.

## Test plan
- Reset, then start=1 and load with mem_ready always 1. Expected states: FETCH, DECODE, MEM, WB. Expected controls: irWrite/pcWrite in cycle 1, memRead in cycle 3, regWrite+memToReg in cycle 4. retired=1.
- Store with mem_ready low for 3 cycles in MEM. Expected: memWrite held high for 4 cycles, no trap, retired increments once.
- With MEM_TIMEOUT=4, hold mem_ready=0 during FETCH. Expected: TRAP after 4 waiting cycles with halt=1, illegal=1, and retired unchanged. A second check asserts mem_ready exactly in cycle 4 and expects no trap.
- With OP_W=4, op=4'b1010 → TRAP. Separately, op=3'b011 → TRAP. Separately, op=111 → HALT with illegal=0, halt stuck at 1 for 10 cycles, retired +1.
- Set CNT_W=2 and run 5 add instructions. Expected: retired reads 1,2,3,0,1. op is changed to garbage after DECODE and must not alter EXEC/WB controls.
- Assert reset asynchronously mid-MEM. Expected: outputs 0 and state IDLE immediately, before the next clock edge. Restarting with start then behaves normally.
